// File: rtl/n64_joybus_rx_if.sv
// Receive-side bundle from the Joybus front end to the SI command decoder / EEPROM emulation.
// master = n64_joybus_rx (drives), slave = downstream consumer.
interface n64_joybus_rx_if;
    logic       byte_valid;
    logic [7:0] data;
    logic [3:0] byte_index;
    logic       frame_start;
    logic       frame_end;
    logic       frame_error;
    logic       busy;

    modport master (
        output byte_valid,
        output data,
        output byte_index,
        output frame_start,
        output frame_end,
        output frame_error,
        output busy
    );

    modport slave (
        input byte_valid,
        input data,
        input byte_index,
        input frame_start,
        input frame_end,
        input frame_error,
        input busy
    );
endinterface

// File: rtl/n64_joybus_rx.sv
// Joybus SI receive front end: pin synchronisers, pulse-width bit decode, byte/frame framing.
// Optional macro JOYBUS_RX_GLITCH_FILTER_EN adds a 3-cycle stability filter on dq (+2 cycles latency).
module n64_joybus_rx #(
    parameter int unsigned SUB_BIT_THRESHOLD = 4,
    parameter int unsigned IDLE_TIMEOUT      = 7
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_n64_reset,
    input  logic            i_n64_si_clk,
    input  logic            i_n64_si_dq,
    input  logic            i_rx_enable,
    n64_joybus_rx_if.master rx
);

    typedef enum logic {
        ST_IDLE,
        ST_FRAME
    } state_t;

    localparam logic [2:0] SUB_THR   = 3'(SUB_BIT_THRESHOLD);
    localparam logic [2:0] IDLE_LAST = 3'(IDLE_TIMEOUT - 1);
    localparam logic [3:0] LAST_IDX  = 4'd15;

    // The N64 reset synchroniser is cleared only by i_reset, so the console
    // reset can release itself once the pin goes high again.
    logic [1:0] n64_reset_sync;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            n64_reset_sync <= 2'b11;
        end else begin
            n64_reset_sync <= {n64_reset_sync[0], i_n64_reset};
        end
    end

    logic rst;
    assign rst = i_reset || !n64_reset_sync[1];

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    logic [1:0] clk_sync;
    logic [1:0] dq_sync;

    always_ff @(posedge i_clk) begin
        if (rst) begin
            clk_sync <= 2'b00;
            dq_sync  <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], i_n64_si_clk};
            dq_sync  <= {dq_sync[0], i_n64_si_dq};
        end
    end

    logic si_clk_line;
    logic dq_line;

`ifdef JOYBUS_RX_GLITCH_FILTER_EN
    // dq must match across three consecutive cycles to be accepted; si_clk is
    // delayed by the same two cycles so each sample still sees the settled level.
    logic [1:0] dq_hist;
    logic [1:0] clk_dly;
    logic       dq_held;
    logic       dq_stable;

    assign dq_stable   = (dq_sync[1] == dq_hist[0]) && (dq_hist[0] == dq_hist[1]);
    assign dq_line     = dq_stable ? dq_sync[1] : dq_held;
    assign si_clk_line = clk_dly[1];

    always_ff @(posedge i_clk) begin
        if (rst) begin
            dq_hist <= 2'b11;
            clk_dly <= 2'b00;
            dq_held <= 1'b1;
        end else begin
            dq_hist <= {dq_hist[0], dq_sync[1]};
            clk_dly <= {clk_dly[0], clk_sync[1]};
            dq_held <= dq_line;
        end
    end
`else
    assign dq_line     = dq_sync[1];
    assign si_clk_line = clk_sync[1];
`endif

    logic si_clk_prev;
    logic dq_smp;
    logic clk_rise;
    logic dq_fall;
    logic dq_rise;

    assign clk_rise = si_clk_line && !si_clk_prev;
    assign dq_fall  = clk_rise && dq_smp && !dq_line;
    assign dq_rise  = clk_rise && !dq_smp && dq_line;

    always_ff @(posedge i_clk) begin
        if (rst) begin
            si_clk_prev <= 1'b0;
            dq_smp      <= 1'b1;
        end else begin
            si_clk_prev <= si_clk_line;
            if (clk_rise) begin
                dq_smp <= dq_line;
            end
        end
    end

    state_t     state;
    logic [2:0] sub_cnt;
    logic [2:0] bit_cnt;
    logic [2:0] idle_cnt;
    logic [3:0] byte_cnt;
    logic [7:0] shreg;
    logic       last_done;
    logic       overflow;
    logic       bit_val;

    assign bit_val = (sub_cnt <= SUB_THR);
    assign rx.busy = (state == ST_FRAME);

    always_ff @(posedge i_clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            sub_cnt        <= '0;
            bit_cnt        <= '0;
            idle_cnt       <= '0;
            byte_cnt       <= '0;
            shreg          <= '0;
            last_done      <= 1'b0;
            overflow       <= 1'b0;
            rx.byte_valid  <= 1'b0;
            rx.data        <= '0;
            rx.byte_index  <= '0;
            rx.frame_start <= 1'b0;
            rx.frame_end   <= 1'b0;
            rx.frame_error <= 1'b0;
        end else begin
            rx.byte_valid  <= 1'b0;
            rx.frame_start <= 1'b0;
            rx.frame_end   <= 1'b0;
            rx.frame_error <= 1'b0;

            if (!i_rx_enable) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (dq_fall) begin
                            state          <= ST_FRAME;
                            rx.frame_start <= 1'b1;
                            sub_cnt        <= '0;
                            bit_cnt        <= '0;
                            idle_cnt       <= '0;
                            byte_cnt       <= '0;
                            last_done      <= 1'b0;
                            overflow       <= 1'b0;
                        end
                    end

                    ST_FRAME: begin
                        if (clk_rise) begin
                            if (dq_fall) begin
                                sub_cnt <= '0;
                            end else if (sub_cnt != 3'd7) begin
                                sub_cnt <= sub_cnt + 3'd1;
                            end

                            if (!dq_line) begin
                                idle_cnt <= '0;
                            end else if (idle_cnt != 3'd7) begin
                                idle_cnt <= idle_cnt + 3'd1;
                            end

                            if (dq_rise) begin
                                shreg   <= {shreg[6:0], bit_val};
                                bit_cnt <= bit_cnt + 3'd1;
                                if (bit_cnt == 3'd7) begin
                                    // Index 15 is the final slot; anything beyond only flags overflow.
                                    if (last_done) begin
                                        overflow <= 1'b1;
                                    end else begin
                                        rx.byte_valid <= 1'b1;
                                        rx.data       <= {shreg[6:0], bit_val};
                                        rx.byte_index <= byte_cnt;
                                        if (byte_cnt == LAST_IDX) begin
                                            last_done <= 1'b1;
                                        end else begin
                                            byte_cnt <= byte_cnt + 4'd1;
                                        end
                                    end
                                end
                            end

                            // A timeout needs dq high, so a falling edge on this sample always wins.
                            if (dq_line && !dq_fall && idle_cnt == IDLE_LAST) begin
                                state          <= ST_IDLE;
                                rx.frame_end   <= 1'b1;
                                rx.frame_error <= overflow || (bit_cnt > 3'd1);
                            end
                        end
                    end

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
